// File: rtl/fys_pkg.sv
// Shared types and constants for the Fisher-Yates permutation reader.
// Default index width, walk FSM states and permutation check targets.
package fys_pkg;

    localparam int FYS_M = 13;
    localparam int FYS_N = 1 << FYS_M;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN
    } fys_state_e;

    // Sum of 0..N-1 for an M-bit index space.
    function automatic longint fys_exp_sum(input int m);
        longint n;
        n = longint'(1) << m;
        return (n * (n - 1)) / 2;
    endfunction

    // XOR of 0..N-1: zero for M >= 2, one for M = 1.
    function automatic int fys_exp_xor(input int m);
        return (m == 1) ? 1 : 0;
    endfunction

    localparam longint FYS_SUM = fys_exp_sum(FYS_M);
    localparam int     FYS_XOR = fys_exp_xor(FYS_M);

endpackage

// File: rtl/fys_perm_reader_fifo.sv
// Two-entry FIFO between the read port and the output stream.
// Head entry is a register so the stream outputs come straight off flops.
module fys_skid_fifo #(
    parameter int W = 27
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output logic         valid,
    output logic [W-1:0] head
);

    logic [W-1:0] ent0;
    logic [W-1:0] ent1;

    // Shift-style storage: ent0 is always the head, empty slots read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            ent0  <= '0;
            ent1  <= '0;
        end else if (flush) begin
            count <= 2'd0;
            ent0  <= '0;
            ent1  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) ent0 <= push_data;
                    else               ent1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    ent1  <= '0;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        ent0 <= push_data;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (count != 2'd0);
    assign head  = ent0;

endmodule

// File: rtl/fys_perm_reader.sv
// Walks the shuffle core's permutation memory and streams (index, value)
// beats downstream while checking that the contents form a permutation.
module fys_perm_reader
    import fys_pkg::*;
#(
    parameter int M = FYS_M
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         perm_done,
    input  logic         abort,
    output logic         rd_en,
    output logic [M-1:0] rd_addr,
    input  logic [M-1:0] rd_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_index,
    output logic [M-1:0] out_value,
    output logic         out_last,
    output logic         busy,
    output logic         walk_done,
    output logic         perm_ok
);

    localparam int SW = 2 * M;
    localparam int W  = 2 * M + 1;

    localparam logic [M-1:0]  LAST_IDX = {M{1'b1}};
    localparam logic [SW-1:0] SUM_EXP  = SW'(fys_exp_sum(M));
    localparam logic [M-1:0]  XOR_EXP  = M'(fys_exp_xor(M));

    fys_state_e    state;
    logic          pd_prev;
    logic [M-1:0]  issue_ctr;
    logic          inflight;
    logic [M-1:0]  infl_idx;
    logic [SW-1:0] sum;
    logic [M-1:0]  xr;

    logic [1:0]    fifo_count;
    logic          fifo_valid;
    logic [W-1:0]  fifo_head;
    logic [W-1:0]  push_data;
    logic          pop;
    logic [2:0]    used;

    logic [M-1:0]  head_idx;
    logic [M-1:0]  head_val;
    logic          head_last;
    logic [SW-1:0] sum_nx;
    logic [M-1:0]  xr_nx;

    assign {head_idx, head_val, head_last} = fifo_head;

    assign pop = fifo_valid & out_ready;

    // A slot freed by this cycle's pop counts as a free credit.
    assign used = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

    assign rd_en   = (state == ST_READ) && (used < 3'd2);
    assign rd_addr = rd_en ? issue_ctr : '0;

    assign push_data = {infl_idx, rd_data, infl_idx == LAST_IDX};

    assign sum_nx = sum + {{M{1'b0}}, head_val};
    assign xr_nx  = xr ^ head_val;

    fys_skid_fifo #(
        .W (W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .push      (inflight),
        .push_data (push_data),
        .pop       (pop),
        .count     (fifo_count),
        .valid     (fifo_valid),
        .head      (fifo_head)
    );

    // Walk FSM, read issue, in-flight tracking and permutation check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pd_prev   <= 1'b1;
            issue_ctr <= '0;
            inflight  <= 1'b0;
            infl_idx  <= '0;
            sum       <= '0;
            xr        <= '0;
            walk_done <= 1'b0;
            perm_ok   <= 1'b0;
        end else begin
            pd_prev   <= perm_done;
            walk_done <= 1'b0;
            inflight  <= rd_en;
            infl_idx  <= issue_ctr;
            if (abort) begin
                state    <= ST_IDLE;
                inflight <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (perm_done && !pd_prev) begin
                            state     <= ST_READ;
                            issue_ctr <= '0;
                            sum       <= '0;
                            xr        <= '0;
                        end
                    end
                    ST_READ: begin
                        if (rd_en) begin
                            issue_ctr <= issue_ctr + 1'b1;
                            if (issue_ctr == LAST_IDX) state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: ;
                    default: state <= ST_IDLE;
                endcase
                if (pop) begin
                    sum <= sum_nx;
                    xr  <= xr_nx;
                    if (head_last) begin
                        state     <= ST_IDLE;
                        walk_done <= 1'b1;
                        perm_ok   <= (sum_nx == SUM_EXP) && (xr_nx == XOR_EXP);
                    end
                end
            end
        end
    end

    assign busy      = (state != ST_IDLE);
    assign out_valid = fifo_valid;
    assign out_index = head_idx;
    assign out_value = head_val;
    assign out_last  = fifo_valid & head_last;

endmodule

// File: tb/tb_fys_perm_reader.sv
// Directed bench for fys_perm_reader at M=4 with a one-cycle-latency
// memory model standing in for the shuffle core read port.
module tb_fys_perm_reader;

    localparam int M = 4;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         perm_done;
    logic         abort;
    logic         rd_en;
    logic [M-1:0] rd_addr;
    logic [M-1:0] rd_data = '0;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] out_index;
    logic [M-1:0] out_value;
    logic         out_last;
    logic         busy;
    logic         walk_done;
    logic         perm_ok;

    logic [M-1:0] mem [N];
    logic [8:0]   beats [$];

    int n_chk = 0;
    int n_err = 0;
    int wd_cnt = 0;

    logic rand_rdy = 1'b0;
    logic stab_en  = 1'b0;
    logic cred_en  = 1'b0;
    int   stab_err = 0;
    int   issued   = 0;
    int   accd     = 0;
    int   max_out  = 0;
    logic         hold_v = 1'b0;
    logic [M-1:0] hold_i = '0;
    logic [M-1:0] hold_x = '0;

    fys_perm_reader #(.M(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .perm_done (perm_done),
        .abort     (abort),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_value (out_value),
        .out_last  (out_last),
        .busy      (busy),
        .walk_done (walk_done),
        .perm_ok   (perm_ok)
    );

    always #5 clk = ~clk;

    // Shuffle core read port: data one cycle after the address.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Stream monitor: beat capture, stability, credits, walk_done count.
    always @(posedge clk) begin
        if (walk_done) wd_cnt++;
        if (out_valid && out_ready)
            beats.push_back({out_index, out_value, out_last});
        if (stab_en && hold_v &&
            !(out_valid && out_index == hold_i && out_value == hold_x))
            stab_err++;
        hold_v = out_valid && !out_ready;
        hold_i = out_index;
        hold_x = out_value;
        if (cred_en) begin
            if (rd_en) issued++;
            if (out_valid && out_ready) accd++;
            if (issued - accd > max_out) max_out = issued - accd;
        end
    end

    // Random downstream backpressure when enabled.
    always @(negedge clk) begin
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_walk(input int budget, output int kv, output int kd);
        kv = -1;
        kd = -1;
        perm_done = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (out_valid && kv < 0) kv = k;
            if (walk_done) begin
                kd = k;
                break;
            end
        end
        perm_done = 1'b0;
    endtask

    task automatic check_beats(input string tag);
        logic [3:0] ii;
        check({tag, "_count"}, beats.size(), N);
        for (int i = 0; i < N && i < beats.size(); i++) begin
            ii = 4'(i);
            check(tag, beats[i], {ii, mem[i], i == N - 1});
        end
    endtask

    task automatic load_identity();
        for (int i = 0; i < N; i++) mem[i] = 4'(i);
    endtask

    int kv;
    int kd;
    int wd0;
    logic got7;
    logic [3:0] pm [N] = '{3, 14, 7, 0, 9, 12, 1, 15, 5, 10, 2, 8, 13, 6, 11, 4};

    initial begin
        rst_n     = 1'b0;
        perm_done = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        load_identity();
        repeat (3) @(negedge clk);
        check("reset_outs",
              {busy, out_valid, rd_en, walk_done, perm_ok, out_last},
              6'b0);
        check("reset_data", {out_index, out_value, rd_addr}, 12'h000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Identity memory, always-ready downstream.
        beats.delete();
        wd0 = wd_cnt;
        run_walk(100, kv, kd);
        check("id_first_valid", kv, 2);
        check("id_walk_done_at", kd, 18);
        check("id_busy_at_done", busy, 0);
        check("id_perm_ok", perm_ok, 1);
        check_beats("id_beat");
        @(negedge clk);
        check("id_done_pulse", walk_done, 0);
        check("id_done_count", wd_cnt - wd0, 1);

        // Shuffled memory with random backpressure.
        for (int i = 0; i < N; i++) mem[i] = pm[i];
        beats.delete();
        stab_err = 0;
        issued   = 0;
        accd     = 0;
        max_out  = 0;
        stab_en  = 1'b1;
        cred_en  = 1'b1;
        rand_rdy = 1'b1;
        run_walk(400, kv, kd);
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        stab_en = 1'b0;
        cred_en = 1'b0;
        check("bp_walk_done", kd >= 0, 1);
        check("bp_stable", stab_err, 0);
        check("bp_credits_le2", max_out <= 2, 1);
        check("bp_perm_ok", perm_ok, 1);
        check_beats("bp_beat");

        // Duplicate entry breaks the permutation.
        load_identity();
        mem[5] = mem[6];
        beats.delete();
        run_walk(100, kv, kd);
        check("dup_walk_done", kd, 18);
        check("dup_perm_ok", perm_ok, 0);
        check_beats("dup_beat");

        // Abort while beat 7 is stalled.
        load_identity();
        @(negedge clk);
        beats.delete();
        got7 = 1'b0;
        perm_done = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_valid && out_index == 4'd7) begin
                out_ready = 1'b0;
                got7 = 1'b1;
                break;
            end
        end
        check("ab_reach_7", got7, 1);
        repeat (3) @(negedge clk);
        check("ab_hold_idx", out_index, 7);
        check("ab_hold_valid", out_valid, 1);
        wd0 = wd_cnt;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_valid", out_valid, 0);
        check("ab_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("ab_no_done", wd_cnt - wd0, 0);
        check("ab_no_restart", busy, 0);
        check("ab_perm_ok_kept", perm_ok, 0);
        perm_done = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        beats.delete();
        run_walk(100, kv, kd);
        check("ab_restart_done", kd, 18);
        check("ab_restart_ok", perm_ok, 1);
        check_beats("ab_beat");

        // Reset mid-walk with perm_done held high.
        @(negedge clk);
        perm_done = 1'b1;
        repeat (6) @(negedge clk);
        check("rs_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rs_outs",
              {busy, out_valid, rd_en, walk_done, perm_ok, out_last},
              6'b0);
        check("rs_data", {out_index, out_value, rd_addr}, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        beats.delete();
        repeat (10) @(negedge clk);
        check("rs_no_walk", busy, 0);
        check("rs_no_beats", beats.size(), 0);
        perm_done = 1'b0;
        @(negedge clk);
        run_walk(100, kv, kd);
        check("rs_rewalk_done", kd, 18);
        check_beats("rs_beat");

        // Long perm_done level gives a single walk.
        @(negedge clk);
        beats.delete();
        wd0 = wd_cnt;
        perm_done = 1'b1;
        repeat (40) @(negedge clk);
        perm_done = 1'b0;
        repeat (10) @(negedge clk);
        check("lv_done_count", wd_cnt - wd0, 1);
        check("lv_beat_count", beats.size(), N);
        check("lv_perm_ok", perm_ok, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
